// File: rtl/pipelined_multiplier_vr.sv
// Streaming DATA_LEN x DATA_LEN multiplier with valid/ready handshakes and an in-flight counter.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module pipelined_multiplier_vr #(
    parameter int unsigned DATA_LEN       = 32,
    parameter int unsigned PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] result,
    output logic [DATA_LEN-1:0] result_hi,
    output logic                overflow,
    output logic [3:0]          in_flight,
    output logic                idle
);

    localparam int unsigned ProdW = 2 * DATA_LEN;
    localparam int unsigned Last  = PIPELINE_STAGE - 1;

    logic                      stall;
    logic                      accept;
    logic                      out_fire;
    logic [ProdW-1:0]          a_ext;
    logic [ProdW-1:0]          b_ext;
    logic [ProdW-1:0]          pp_lo;
    logic [DATA_LEN-1:0]       pp_hi;
    logic [PIPELINE_STAGE-1:0] vld_q, vld_d;
    logic [ProdW-1:0]          prod_q [PIPELINE_STAGE];
    logic [ProdW-1:0]          prod_d [PIPELINE_STAGE];
    logic [DATA_LEN-1:0]       hi_q, hi_d;
    logic [3:0]                cnt_q, cnt_d;

`ifdef MULT_SIGNED_EN
    assign a_ext = {{DATA_LEN{a[DATA_LEN-1]}}, a};
    assign b_ext = {{DATA_LEN{b[DATA_LEN-1]}}, b};
`else
    assign a_ext = {{DATA_LEN{1'b0}}, a};
    assign b_ext = {{DATA_LEN{1'b0}}, b};
`endif

    // Product modulo 2^ProdW as lo-half and hi-half partial products; the hi-half term only
    // contributes its low DATA_LEN bits once shifted up, so it is kept at DATA_LEN width.
    assign pp_lo = a_ext * {{DATA_LEN{1'b0}}, b_ext[DATA_LEN-1:0]};
    assign pp_hi = a * b_ext[ProdW-1:DATA_LEN];

    assign out_valid = vld_q[Last];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        vld_d  = vld_q;
        prod_d = prod_q;
        hi_d   = hi_q;
        if (!stall) begin
            vld_d[0] = accept;
            for (int k = 1; k < PIPELINE_STAGE; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
        // Data registers load only behind a valid op so undriven operands never propagate.
        if (accept) begin
            if (PIPELINE_STAGE == 1) begin
                prod_d[0] = pp_lo + {pp_hi, {DATA_LEN{1'b0}}};
            end else begin
                prod_d[0] = pp_lo;
                hi_d      = pp_hi;
            end
        end
        if (!stall) begin
            for (int k = 1; k < PIPELINE_STAGE; k++) begin
                if (vld_q[k-1]) begin
                    if (k == 1) begin
                        prod_d[k] = prod_q[0] + {hi_q, {DATA_LEN{1'b0}}};
                    end else begin
                        prod_d[k] = prod_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, out_fire})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            prod_q <= '{default: '0};
            hi_q   <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            prod_q <= prod_d;
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
        end
    end

    assign result    = prod_q[Last][DATA_LEN-1:0];
    assign result_hi = prod_q[Last][ProdW-1:DATA_LEN];
    assign in_flight = cnt_q;
    assign idle      = (cnt_q == 4'd0);

`ifdef MULT_SIGNED_EN
    assign overflow = (result_hi != {DATA_LEN{result[DATA_LEN-1]}});
`else
    assign overflow = (result_hi != '0);
`endif

endmodule
